branch_target_buffer: RTL and testbench

//  Direct-mapped branch target buffer (BTB) for the 5-stage pipeline.
//  - IF stage: looks up the fetch PC combinationally; on a hit, redirects the next PC to the stored target.
//  - EX stage: takes the 2-bit update command from the branch judge and

---
 rtl/btb_pkg.sv | 26 ++
 rtl/sat_counter.sv | 30 +++
 rtl/branch_target_buffer.sv | 97 +++++++++
 tb/tb_branch_target_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared command encoding and PC field helpers for the branch target buffer.
package btb_pkg;

  localparam int unsigned BTB_PC_W = 32;

  typedef logic [1:0] btb_cmd_t;

  localparam btb_cmd_t BTB_CMD_NONE   = 2'b00;
  localparam btb_cmd_t BTB_CMD_INSERT = 2'b01;
  localparam btb_cmd_t BTB_CMD_INVAL  = 2'b10;

  // Index field pc[idx_bits+1:2], right-aligned; callers truncate to idx_bits.
  function automatic logic [BTB_PC_W-1:0] btb_idx(input logic [BTB_PC_W-1:0] pc,
                                                  input int unsigned idx_bits);
    logic [BTB_PC_W-1:0] mask;
    mask = (BTB_PC_W'(1) << idx_bits) - BTB_PC_W'(1);
    return (pc >> 2) & mask;
  endfunction

  // Tag field pc[31:idx_bits+2], right-aligned.
  function automatic logic [BTB_PC_W-1:0] btb_tag(input logic [BTB_PC_W-1:0] pc,
                                                  input int unsigned idx_bits);
    return pc >> (idx_bits + 2);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en_i && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational IF-stage lookup, EX-stage insert/invalidate,
// and saturating lookup/hit statistics.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_f,
  input  logic             stall_f,
  output logic             pred_taken_f,
  output logic [31:0]      pred_npc_f,
  input  logic [1:0]       upd_cmd_e,
  input  logic [31:0]      upd_pc_e,
  input  logic [31:0]      upd_tgt_e,
  input  logic             stall_e,
  output logic [CNT_W-1:0] cnt_lookup,
  output logic [CNT_W-1:0] cnt_hit
);

  localparam int unsigned Entries = 2 ** IDX_BITS;
  localparam int unsigned TagW    = 32 - IDX_BITS - 2;

  logic [IDX_BITS-1:0] idx_f, idx_e;
  logic [TagW-1:0]     tag_f, tag_e;
  btb_cmd_t            upd_cmd;
  logic                upd_en;
  logic                lookup_hit;

  logic [Entries-1:0]  valid_q, valid_d;
  logic [TagW-1:0]     tag_q [Entries];
  logic [31:0]         tgt_q [Entries];

  assign idx_f   = IDX_BITS'(btb_idx(pc_f, IDX_BITS));
  assign tag_f   = TagW'(btb_tag(pc_f, IDX_BITS));
  assign idx_e   = IDX_BITS'(btb_idx(upd_pc_e, IDX_BITS));
  assign tag_e   = TagW'(btb_tag(upd_pc_e, IDX_BITS));
  assign upd_cmd = btb_cmd_t'(upd_cmd_e);
  assign upd_en  = !rst && !stall_e;

  // Valid gates the compare so uninitialised tag/target never reach the outputs.
  assign lookup_hit   = !rst && valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign pred_taken_f = lookup_hit;
  assign pred_npc_f   = lookup_hit ? tgt_q[idx_f] : pc_f + 32'd4;

  always_comb begin
    valid_d = valid_q;
    if (upd_en) begin
      case (upd_cmd)
        BTB_CMD_INSERT: valid_d[idx_e] = 1'b1;
        BTB_CMD_INVAL: begin
          if (tag_q[idx_e] == tag_e) begin
            valid_d[idx_e] = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and target carry no reset; an insert simply evicts whatever aliased there.
  always_ff @(posedge clk) begin
    if (upd_en && (upd_cmd == BTB_CMD_INSERT)) begin
      tag_q[idx_e] <= tag_e;
      tgt_q[idx_e] <= upd_tgt_e;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt_lookup (
    .clk_i (clk),
    .clr_i (rst),
    .en_i  (!stall_f),
    .q_o   (cnt_lookup)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_cnt_hit (
    .clk_i (clk),
    .clr_i (rst),
    .en_i  (!stall_f && lookup_hit),
    .q_o   (cnt_hit)
  );

endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomised self-checking bench for branch_target_buffer against an array-based model.
module tb_branch_target_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] pc_f;
  logic        stall_f;
  logic [1:0]  upd_cmd_e;
  logic [31:0] upd_pc_e;
  logic [31:0] upd_tgt_e;
  logic        stall_e;

  logic        taken, taken4;
  logic [31:0] npc, npc4;
  logic [31:0] cl, ch;
  logic [3:0]  cl4, ch4;

  int n_cmp;
  int n_err;

  // Reference state: one entry per (pc / 4) mod 64 slot, tag = pc / 256.
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  longint unsigned m_look, m_hit, m_look4, m_hit4;

  logic        obs_taken;
  logic [31:0] obs_npc;

  branch_target_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .pc_f         (pc_f),
    .stall_f      (stall_f),
    .pred_taken_f (taken),
    .pred_npc_f   (npc),
    .upd_cmd_e    (upd_cmd_e),
    .upd_pc_e     (upd_pc_e),
    .upd_tgt_e    (upd_tgt_e),
    .stall_e      (stall_e),
    .cnt_lookup   (cl),
    .cnt_hit      (ch)
  );

  branch_target_buffer #(
    .CNT_W (4)
  ) dut4 (
    .clk          (clk),
    .rst          (rst),
    .pc_f         (pc_f),
    .stall_f      (stall_f),
    .pred_taken_f (taken4),
    .pred_npc_f   (npc4),
    .upd_cmd_e    (upd_cmd_e),
    .upd_pc_e     (upd_pc_e),
    .upd_tgt_e    (upd_tgt_e),
    .stall_e      (stall_e),
    .cnt_lookup   (cl4),
    .cnt_hit      (ch4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned sat_inc(input longint unsigned v,
                                              input longint unsigned max);
    return (v >= max) ? max : v + 1;
  endfunction

  // One clock: drive, check combinational lookup mid-cycle, advance model, check counters.
  task automatic step(input logic r, input logic sf, input logic [31:0] pc,
                      input logic [1:0] cmd, input logic [31:0] upc,
                      input logic [31:0] utgt, input logic se);
    int          i_f, i_e;
    logic [31:0] t_f, t_e;
    bit          hit;
    logic [31:0] enpc;
    rst = r; stall_f = sf; pc_f = pc;
    upd_cmd_e = cmd; upd_pc_e = upc; upd_tgt_e = utgt; stall_e = se;
    @(negedge clk);
    i_f  = int'((pc >> 2) % 64);
    t_f  = pc / 256;
    hit  = !r && m_valid[i_f] && (m_tag[i_f] == t_f);
    enpc = hit ? m_tgt[i_f] : pc + 32'd4;
    check_eq("taken", {63'd0, taken}, {63'd0, hit});
    check_eq("npc", {32'd0, npc}, {32'd0, enpc});
    check_eq("taken4", {63'd0, taken4}, {63'd0, hit});
    check_eq("npc4", {32'd0, npc4}, {32'd0, enpc});
    obs_taken = taken;
    obs_npc   = npc;
    @(posedge clk);
    i_e = int'((upc >> 2) % 64);
    t_e = upc / 256;
    if (r) begin
      for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
      m_look = 0; m_hit = 0; m_look4 = 0; m_hit4 = 0;
    end else begin
      if (!se) begin
        if (cmd == 2'b01) begin
          m_valid[i_e] = 1'b1;
          m_tag[i_e]   = t_e;
          m_tgt[i_e]   = utgt;
        end else if (cmd == 2'b10 && m_tag[i_e] == t_e) begin
          m_valid[i_e] = 1'b0;
        end
      end
      if (!sf) begin
        m_look  = sat_inc(m_look, 64'hFFFF_FFFF);
        m_look4 = sat_inc(m_look4, 15);
        if (hit) begin
          m_hit  = sat_inc(m_hit, 64'hFFFF_FFFF);
          m_hit4 = sat_inc(m_hit4, 15);
        end
      end
    end
    #1;
    check_eq("cnt_lookup", {32'd0, cl}, m_look);
    check_eq("cnt_hit", {32'd0, ch}, m_hit);
    check_eq("cnt_lookup4", {60'd0, cl4}, m_look4);
    check_eq("cnt_hit4", {60'd0, ch4}, m_hit4);
  endtask

  task automatic look(input logic [31:0] pc);
    step(1'b0, 1'b0, pc, 2'b00, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] tags [4];
    logic [31:0] rpc, rupc;
    n_cmp = 0; n_err = 0;
    m_look = 0; m_hit = 0; m_look4 = 0; m_hit4 = 0;
    for (int k = 0; k < 64; k++) begin
      m_valid[k] = 1'b0; m_tag[k] = '0; m_tgt[k] = '0;
    end
    rst = 1'b1; stall_f = 1'b0; pc_f = 32'h40;
    upd_cmd_e = 2'b00; upd_pc_e = '0; upd_tgt_e = '0; stall_e = 1'b0;
    @(posedge clk); #1;

    // Reset cycles; reset also drops a concurrent insert.
    step(1'b1, 1'b0, 32'h40, 2'b00, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h40, 2'b01, 32'h40, 32'h999, 1'b0);
    check_eq("rst_taken", {63'd0, obs_taken}, 64'd0);
    check_eq("rst_npc", {32'd0, obs_npc}, 64'h44);

    look(32'h40);
    check_eq("t1_taken", {63'd0, obs_taken}, 64'd0);
    check_eq("t1_npc", {32'd0, obs_npc}, 64'h44);
    check_eq("t1_cnt", {32'd0, cl}, 64'd1);

    step(1'b0, 1'b0, 32'h40, 2'b01, 32'h40, 32'h100, 1'b0);
    look(32'h40);
    check_eq("t2_taken", {63'd0, obs_taken}, 64'd1);
    check_eq("t2_npc", {32'd0, obs_npc}, 64'h100);
    check_eq("t2_hit", {32'd0, ch}, 64'd1);

    step(1'b0, 1'b0, 32'h0, 2'b01, 32'h1040, 32'h2000, 1'b0);
    look(32'h40);
    check_eq("t3_alias_npc", {32'd0, obs_npc}, 64'h44);
    look(32'h1040);
    check_eq("t3_new_npc", {32'd0, obs_npc}, 64'h2000);

    step(1'b0, 1'b0, 32'h1040, 2'b10, 32'h40, 32'h0, 1'b0);
    look(32'h1040);
    check_eq("t4_kept", {63'd0, obs_taken}, 64'd1);
    step(1'b0, 1'b0, 32'h1040, 2'b10, 32'h1040, 32'h0, 1'b0);
    look(32'h1040);
    check_eq("t4_gone", {32'd0, obs_npc}, 64'h1044);

    step(1'b0, 1'b0, 32'h80, 2'b01, 32'h80, 32'h300, 1'b0);
    check_eq("t5_same_cycle", {63'd0, obs_taken}, 64'd0);
    look(32'h80);
    check_eq("t5_next_cycle", {32'd0, obs_npc}, 64'h300);
    step(1'b0, 1'b0, 32'h0, 2'b01, 32'hC0, 32'h400, 1'b1);
    look(32'hC0);
    check_eq("t5_stall_e", {32'd0, obs_npc}, 64'hC4);
    look(32'hFFFF_FFFC);
    check_eq("t5_wrap", {32'd0, obs_npc}, 64'h0);
    step(1'b0, 1'b1, 32'h80, 2'b00, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h80, 2'b11, 32'h80, 32'h0, 1'b0);

    for (int k = 0; k < 20; k++) look(32'h80);
    check_eq("t6_sat_lookup", {60'd0, cl4}, 64'd15);
    check_eq("t6_sat_hit", {60'd0, ch4}, 64'd15);
    step(1'b1, 1'b0, 32'h80, 2'b00, 32'h0, 32'h0, 1'b0);
    check_eq("t6_rst_cnt", {32'd0, cl}, 64'd0);
    look(32'h80);
    check_eq("t6_rst_valid", {63'd0, obs_taken}, 64'd0);

    // Few tags over few indices so aliasing, hits and invalidates are frequent.
    tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h10; tags[3] = 32'hFF_FFFF;
    for (int n = 0; n < 2000; n++) begin
      rpc  = (tags[$urandom_range(3)] << 8) | (32'($urandom_range(7)) << 2)
           | 32'($urandom_range(3));
      rupc = (tags[$urandom_range(3)] << 8) | (32'($urandom_range(7)) << 2)
           | 32'($urandom_range(3));
      if ($urandom_range(9) == 0) rpc = $urandom;
      step(($urandom_range(99) < 2), ($urandom_range(4) == 0), rpc,
           2'($urandom_range(3)), rupc, $urandom, ($urandom_range(4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
